led_flow_ctrl: RTL

Run/pause and pattern controller for the flowing-light datapath. It debounces the raw S2 button into single press events and runs a run/pause state machine that gates the LED shifter. In auto mode it steps through a fixed four-entry program of (frequency, direction, step count), using the shifter's per-move tick, and drives the shifter's `freq_set`/`dir_set`. In manual mode those outputs follow the board switches.

---
 rtl/led_ctrl_pkg.sv | 43 ++++
 rtl/key_debounce.sv | 47 ++++
 rtl/led_flow_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and the fixed auto-mode program for the flowing-light controller.
// LED_SEQ_LOOP_EN selects a looping program (no DONE state) instead of a one-shot run.
package led_ctrl_pkg;

`ifdef LED_SEQ_LOOP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;
`endif

    localparam logic [1:0] FREQ_1000HZ = 2'b00;
    localparam logic [1:0] FREQ_500HZ  = 2'b01;
    localparam logic [1:0] FREQ_20HZ   = 2'b10;
    localparam logic [1:0] FREQ_5HZ    = 2'b11;

    typedef struct packed {
        logic [1:0] freq;
        logic       dir;
        logic [3:0] steps;
    } prog_entry_t;

    localparam prog_entry_t [0:3] PROG = '{
        '{freq: FREQ_1000HZ, dir: 1'b0, steps: 4'd8},
        '{freq: FREQ_500HZ,  dir: 1'b1, steps: 4'd8},
        '{freq: FREQ_20HZ,   dir: 1'b0, steps: 4'd4},
        '{freq: FREQ_5HZ,    dir: 1'b1, steps: 4'd4}
    };

    // A zero step count would never complete an entry, so it behaves as one step.
    function automatic logic [3:0] eff_steps(input logic [3:0] steps);
        return (steps == 4'd0) ? 4'd1 : steps;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted 0->1 transition (releases are accepted silently).
module key_debounce #(
    parameter int DEBOUNCE_CNT = 999_999
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    localparam int CW = (DEBOUNCE_CNT < 1) ? 1 : $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                // Level differed for DEBOUNCE_CNT+1 consecutive cycles: accept it.
                cnt_q   <= '0;
                level_q <= sync2_q;
                press_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_flow_ctrl.sv
// Run/pause FSM, auto-program stepping and frequency/direction selection for
// the LED shifter. Build option: LED_SEQ_LOOP_EN (loop the program forever).
module led_flow_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 999_999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic       auto_mode,
    input  logic [1:0] sw_freq,
    input  logic       sw_dir,
    input  logic       step_tick,
    output logic       run,
    output logic [1:0] freq_set,
    output logic       dir_set,
    output logic [1:0] seq_idx
);

    logic        press;
    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        auto_q;
    logic        run_q;
    logic [1:0]  freq_q, freq_d;
    logic        dir_q, dir_d;
    prog_entry_t cur_entry;
    prog_entry_t next_entry;
    logic        mode_change;
    logic        last_step;

    key_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_key_debounce (
        .clk   (clk),
        .rst   (rst),
        .button(button),
        .press (press)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            auto_q  <= 1'b0;
            run_q   <= 1'b0;
            freq_q  <= FREQ_1000HZ;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            auto_q  <= auto_mode;
            run_q   <= (state_d == ST_RUN);
            freq_q  <= freq_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cur_entry   = PROG[idx_q];
        mode_change = (auto_mode != auto_q);
        last_step   = (cnt_q == eff_steps(cur_entry.steps) - 4'd1);

        if (mode_change) begin
            idx_d = 2'd0;
            cnt_d = 4'd0;
        end

        // A press wins over a coincident tick; the tick is simply dropped.
        if (press) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                end
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
`ifdef LED_SEQ_LOOP_EN
`else
                ST_DONE: begin
                    state_d = ST_RUN;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                end
`endif
                default:  state_d = ST_IDLE;
            endcase
        end else if (state_q == ST_RUN && auto_mode && !mode_change && step_tick) begin
            if (last_step) begin
                cnt_d = 4'd0;
                if (idx_q == 2'd3) begin
`ifdef LED_SEQ_LOOP_EN
                    idx_d = 2'd0;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end

        next_entry = PROG[idx_d];
        freq_d     = auto_mode ? next_entry.freq : sw_freq;
        dir_d      = auto_mode ? next_entry.dir  : sw_dir;
    end

    assign run      = run_q;
    assign freq_set = freq_q;
    assign dir_set  = dir_q;
    assign seq_idx  = idx_q;

endmodule
